// File: rtl/seq_mag_comparator_if.sv
// seq_mag_comparator_if: start/operand request and busy/done/result response bundle.
interface seq_mag_comparator_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    modport master (output start, a, b, is_signed, input busy, done, eq, gt, lt);
    modport slave  (input start, a, b, is_signed, output busy, done, eq, gt, lt);
endinterface

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: MSB-first digit-serial magnitude comparator, signed/unsigned per operation.
// SEQ_MAG_COMPARATOR_EARLY_EXIT_EN: finish on the first differing digit instead of constant NDIG latency.
module seq_mag_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic clk,
    input logic rst,
    seq_mag_comparator_if.slave bus
);
    if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("seq_mag_comparator: WIDTH >= 2, DIGIT >= 1 and WIDTH %% DIGIT == 0 required");
    end

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             decided, res_gt;
    logic             eq, gt, lt;
    logic [DIGIT-1:0] digit_a, digit_b;
    logic             differ, fin, dec_n, gt_n, accept;
    logic [WIDTH-1:0] msb_flip;

    assign digit_a  = sa[WIDTH-1 -: DIGIT];
    assign digit_b  = sb[WIDTH-1 -: DIGIT];
    assign differ   = digit_a != digit_b;
    assign dec_n    = decided | differ;
    assign gt_n     = decided ? res_gt : (digit_a > digit_b);
    assign accept   = bus.start && (state != S_RUN);
    // Flipping both MSBs maps two's-complement order onto unsigned order.
    assign msb_flip = {bus.is_signed, {(WIDTH-1){1'b0}}};
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
    assign fin = (cnt == CW'(NDIG-1)) || (!decided && differ);
`else
    assign fin = cnt == CW'(NDIG-1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            res_gt  <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else if (state == S_RUN) begin
            decided <= dec_n;
            res_gt  <= gt_n;
            sa      <= sa << DIGIT;
            sb      <= sb << DIGIT;
            cnt     <= cnt + 1'b1;
            if (fin) begin
                state <= S_DONE;
                eq    <= !dec_n;
                gt    <= dec_n & gt_n;
                lt    <= dec_n & !gt_n;
            end
        end else if (accept) begin
            state   <= S_RUN;
            sa      <= bus.a ^ msb_flip;
            sb      <= bus.b ^ msb_flip;
            cnt     <= '0;
            decided <= 1'b0;
            res_gt  <= 1'b0;
        end else begin
            state <= S_IDLE;
        end
    end

    assign bus.busy = state == S_RUN;
    assign bus.done = state == S_DONE;
    assign bus.eq   = eq;
    assign bus.gt   = gt;
    assign bus.lt   = lt;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: directed + random checks of seq_mag_comparator (WIDTH=32, DIGIT=4).
module tb_seq_mag_comparator;
    localparam int W = 32;
    localparam int D = 4;
    localparam int ND = W / D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    seq_mag_comparator_if #(.WIDTH(W)) bus();
    seq_mag_comparator #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return {x == y, x > y, x < y};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
        logic [W-1:0] x, y;
        x = s ? a ^ (1 << (W - 1)) : a;
        y = s ? b ^ (1 << (W - 1)) : b;
        for (int k = 1; k <= ND; k++)
            if (x[W-1-D*(k-1) -: D] != y[W-1-D*(k-1) -: D]) return k + 1;
`endif
        return ND + 1;
    endfunction

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!bus.done && n < 40) begin
            chk("busy_run", bus.busy, 1);
            tick();
            n++;
        end
    endtask

    task automatic check_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int n);
        logic [2:0] r;
        r = ref_cmp(a, b, s);
        chk("done", bus.done, 1);
        chk("busy_in_done", bus.busy, 0);
        chk("latency", n, exp_lat(a, b, s));
        chk("eq", bus.eq, r[2]);
        chk("gt", bus.gt, r[1]);
        chk("lt", bus.lt, r[0]);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int n;
        logic [2:0] r;
        bus.a = a;
        bus.b = b;
        bus.is_signed = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.is_signed = 1'($urandom);
        wait_done(1, n);
        check_res(a, b, s, n);
        tick();
        r = ref_cmp(a, b, s);
        chk("done_drop", bus.done, 0);
        chk("hold", {bus.eq, bus.gt, bus.lt}, r);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.is_signed = 1'b0;
        #12;
        chk("reset_outs", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 0);
        rst = 1'b0;
        tick();
        chk("idle_outs", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 0);

        run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        run_op(32'h80000000, 32'h7FFFFFFF, 1'b0);
        run_op(32'h80000000, 32'h7FFFFFFF, 1'b1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        run_op(32'h00000000, 32'h00000001, 1'b1);
        run_op(32'hF0000000, 32'h00000000, 1'b0);
        run_op(32'h7FFFFFFF, 32'h80000000, 1'b1);
        run_op(32'h00000000, 32'hFFFFFFFF, 1'b0);

        // abort in the 3rd RUN cycle
        bus.a = 32'h12345678;
        bus.b = 32'h12345678;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("busy_before_abort", bus.busy, 1);
        #2 rst = 1'b1;
        #1 chk("abort_outs", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_done_after_abort", {bus.busy, bus.done}, 0);
        end
        run_op(32'd5, 32'd9, 1'b0);

        // start held high with operands changed mid-RUN
        bus.a = 32'h12345678;
        bus.b = 32'h12345678;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        bus.a = 32'h12345679;
        wait_done(3, n);
        check_res(32'h12345678, 32'h12345678, 1'b0, n);
        tick();
        wait_done(1, n);
        check_res(32'h12345679, 32'h12345678, 1'b0, n);
        bus.start = 1'b0;
        tick();
        chk("held_done_drop", bus.done, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 4)
                0: rb = ra;
                1: rb = {ra[W-1:W-12], rb[W-13:0]};
                2: rb = ra ^ (32'h1 << $urandom_range(W - 1, 0));
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
